store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write FIFO between the MIPS core data port (memwrite/dataadr/writedata) and data memory.
//  Accepts core stores in one cycle, drains them to memory under a ready handshake, and
//  stalls the core only when full. Loads that hit a queued store get the youngest matching
//  data forwarded, so program order is preserved.
// PARAMETERS
//  DEPTH  4   number of store entries (power of two, >=2)
//  AW     32  address width
//  DW     32  data width
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   synchronous, active-high
//  memwrite   in   1   core store request this cycle
//  dataadr    in   AW  core byte address (store or load)
//  writedata  in   DW  core store data
//  memread    in   1   core load request this cycle
//  stall      out  1   core must hold the current store; comb = memwrite & full
//  fwd_hit    out  1   load address matches a queued entry; comb
//  fwd_data   out  DW  data of the youngest matching entry; 0 when !fwd_hit
//  mem_we     out  1   head entry valid toward memory (= !empty)
//  mem_adr    out  AW  head entry address
//  mem_wd     out  DW  head entry data
//  mem_ready  in   1   memory accepts the head entry at this edge
//  empty      out  1   no pending stores; drain/fence indicator
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, count=0. Outputs: empty=1, mem_we=0, stall=0, fwd_hit=0.
//    mem_adr/mem_wd read as 0 (entries cleared). Reset mid-drain discards all entries.
//  - push = memwrite & !full; pop = mem_we & mem_ready; both take effect at the rising edge.
//  - count' = count + push - pop; range 0..DEPTH. full = (count==DEPTH).
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  - Latency: a store pushed at edge N into an empty buffer drives mem_we=1 in cycle N+1.
//  - Simultaneous push and pop: when not full, both happen and count is unchanged.
//    When full, push is refused (stall=1) even if pop occurs that edge. The store is
//    accepted on the next edge.
//  - stall does not depend on mem_ready, so there is no comb path mem_ready->stall.
//  - The core holds memwrite/dataadr/writedata stable while stall=1.
//  - Empty with no push: mem_we=0; mem_adr/mem_wd keep the stale head value and are don't-care.
//  - Forwarding:
//    - compare dataadr[AW-1:2] against every valid entry's adr[AW-1:2] (word granularity);
//    - on multiple matches, select the youngest (closest behind wr_ptr);
//    - evaluated only when memread=1, otherwise fwd_hit=0;
//    - an entry popped at this edge still forwards in this cycle;
//    - a store pushed at this edge is not visible until the next cycle.
//  - memwrite & memread in the same cycle is illegal (single-port core); behaviour is unspecified.
//  - Stores are kept in order; no coalescing. Two stores to the same address give two memory writes.
// TESTING
//  1. Reset held 2 cycles, then released -> empty=1, mem_we=0, stall=0 on the first cycle after reset.
//  2. Store 7 to 84 with mem_ready=1 -> next cycle mem_we=1, mem_adr=84, mem_wd=7; the cycle
//     after that, empty=1.
//  3. mem_ready=0, then stores to 80,84,88,92 and a 5th to 96 -> stall=1 on the 5th.
//     Raise mem_ready -> 80 drains and 96 is accepted on the following edge. Drain order must be
//     80,84,88,92,96.
//  4. Stores 5->84 then 7->84 queued, then load from 86 -> fwd_hit=1, fwd_data=7.
//     Load from 100 -> fwd_hit=0, fwd_data=0.
//  5. Wrap: 3*DEPTH stores with mem_ready toggling every cycle -> every write reaches memory
//     in order, count never exceeds DEPTH.
//  6. Assert reset with 3 entries pending -> next cycle empty=1, mem_we=0, no further memory writes.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core data port and data memory, with
// youngest-match store-to-load forwarding at word granularity.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    input  logic          memread,
    output logic          stall,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic          mem_ready,
    output logic          empty
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]    adr_q  [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             full, push, pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // Stall depends only on local state, never on mem_ready.
    assign stall   = memwrite & full;
    assign push    = memwrite & ~full;
    assign mem_we  = ~empty;
    assign pop     = mem_we & mem_ready;
    assign mem_adr = adr_q[rd_ptr_q];
    assign mem_wd  = data_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                adr_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // push and pop never target the same slot: wr==rd with a pop means full.
            if (push) begin
                adr_q[wr_ptr_q]  <= dataadr;
                data_q[wr_ptr_q] <= writedata;
                vld_q[wr_ptr_q]  <= 1'b1;
            end
            if (pop) vld_q[rd_ptr_q] <= 1'b0;
        end
    end

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (memread) begin
            for (int k = DEPTH-1; k >= 0; k--) begin
                idx = wr_ptr_q - PW'(k + 1);
                if (vld_q[idx] && (adr_q[idx][AW-1:2] == dataadr[AW-1:2])) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_q[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: vector table plus wrap and reset sequences.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0, memread = 1'b0, mem_ready = 1'b0;
    logic [31:0] dataadr = '0, writedata = '0;
    logic        stall, fwd_hit, mem_we, empty;
    logic [31:0] fwd_data, mem_adr, mem_wd;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .memread(memread), .stall(stall),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .mem_we(mem_we),
        .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_ready(mem_ready), .empty(empty)
    );

    typedef struct {
        logic        rst, we, rd, rdy;
        logic [31:0] adr, wd;
        logic        e_stall, e_hit;
        logic [31:0] e_fwd;
        logic        e_we;
        logic [31:0] e_adr, e_wd;
        logic        e_empty, chk_head;
    } vec_t;

    vec_t vecs[30];

    function automatic vec_t v(input logic rst, we, input logic [31:0] adr, wd,
                               input logic rd, rdy, e_stall, e_hit, input logic [31:0] e_fwd,
                               input logic e_we, input logic [31:0] e_adr, e_wd,
                               input logic e_empty, chk_head);
        vec_t r;
        r.rst = rst; r.we = we; r.adr = adr; r.wd = wd; r.rd = rd; r.rdy = rdy;
        r.e_stall = e_stall; r.e_hit = e_hit; r.e_fwd = e_fwd; r.e_we = e_we;
        r.e_adr = e_adr; r.e_wd = e_wd; r.e_empty = e_empty; r.chk_head = chk_head;
        return r;
    endfunction

    task automatic check(input string name, input int tag, input logic [31:0] act, exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0d, expected %0d", name, tag, act, exp);
    endtask

    task automatic drive(input logic rst, we, input logic [31:0] adr, wd, input logic rd, rdy);
        reset = rst; memwrite = we; dataadr = adr; writedata = wd; memread = rd; mem_ready = rdy;
    endtask

    initial begin
        int sent, popped, mcount;
        logic p_push, p_pop;

        //         rst we adr  wd rd rdy  stl hit fwd  we adr wd  emp hd
        vecs[0]  = v(1, 0,   0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 1, 1);
        vecs[1]  = v(1, 0,   0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 1, 1);
        vecs[2]  = v(0, 0,   0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 1, 1);
        vecs[3]  = v(0, 1,  84, 7, 0, 1,  0, 0, 0,  0,  0, 0, 1, 1);
        vecs[4]  = v(0, 0,   0, 0, 0, 1,  0, 0, 0,  1, 84, 7, 0, 1);
        vecs[5]  = v(0, 0,   0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 1, 0);
        vecs[6]  = v(0, 1,  80, 1, 0, 0,  0, 0, 0,  0,  0, 0, 1, 0);
        vecs[7]  = v(0, 1,  84, 2, 0, 0,  0, 0, 0,  1, 80, 1, 0, 1);
        vecs[8]  = v(0, 1,  88, 3, 0, 0,  0, 0, 0,  1, 80, 1, 0, 1);
        vecs[9]  = v(0, 1,  92, 4, 0, 0,  0, 0, 0,  1, 80, 1, 0, 1);
        vecs[10] = v(0, 1,  96, 5, 0, 0,  1, 0, 0,  1, 80, 1, 0, 1);
        vecs[11] = v(0, 1,  96, 5, 0, 1,  1, 0, 0,  1, 80, 1, 0, 1);
        vecs[12] = v(0, 1,  96, 5, 0, 0,  0, 0, 0,  1, 84, 2, 0, 1);
        vecs[13] = v(0, 0,   0, 0, 0, 1,  0, 0, 0,  1, 84, 2, 0, 1);
        vecs[14] = v(0, 0,   0, 0, 0, 1,  0, 0, 0,  1, 88, 3, 0, 1);
        vecs[15] = v(0, 0,   0, 0, 0, 1,  0, 0, 0,  1, 92, 4, 0, 1);
        vecs[16] = v(0, 0,   0, 0, 0, 1,  0, 0, 0,  1, 96, 5, 0, 1);
        vecs[17] = v(0, 0,   0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 1, 0);
        vecs[18] = v(0, 1,  84, 5, 0, 0,  0, 0, 0,  0,  0, 0, 1, 0);
        vecs[19] = v(0, 1,  84, 7, 0, 0,  0, 0, 0,  1, 84, 5, 0, 1);
        vecs[20] = v(0, 0,  86, 0, 1, 0,  0, 1, 7,  1, 84, 5, 0, 1);
        vecs[21] = v(0, 0, 100, 0, 1, 0,  0, 0, 0,  1, 84, 5, 0, 1);
        vecs[22] = v(0, 0,  84, 0, 0, 0,  0, 0, 0,  1, 84, 5, 0, 1);
        vecs[23] = v(0, 0,  84, 0, 1, 1,  0, 1, 7,  1, 84, 5, 0, 1);
        vecs[24] = v(0, 0,  84, 0, 1, 1,  0, 1, 7,  1, 84, 7, 0, 1);
        vecs[25] = v(0, 0,  84, 0, 1, 0,  0, 0, 0,  0,  0, 0, 1, 0);
        vecs[26] = v(0, 1, 200, 9, 0, 0,  0, 0, 0,  0,  0, 0, 1, 0);
        vecs[27] = v(0, 0, 203, 0, 1, 0,  0, 1, 9,  1,200, 9, 0, 1);
        vecs[28] = v(0, 0,   0, 0, 1, 1,  0, 0, 0,  1,200, 9, 0, 1);
        vecs[29] = v(0, 0,   0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 1, 0);

        // Each row's inputs are live for one cycle; outputs sampled mid-cycle.
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].rst, vecs[i].we, vecs[i].adr, vecs[i].wd, vecs[i].rd, vecs[i].rdy);
            @(negedge clk);
            check("stall",    i, 32'(stall),   32'(vecs[i].e_stall));
            check("fwd_hit",  i, 32'(fwd_hit), 32'(vecs[i].e_hit));
            check("fwd_data", i, fwd_data,     vecs[i].e_fwd);
            check("mem_we",   i, 32'(mem_we),  32'(vecs[i].e_we));
            check("empty",    i, 32'(empty),   32'(vecs[i].e_empty));
            if (vecs[i].chk_head) begin
                check("mem_adr", i, mem_adr, vecs[i].e_adr);
                check("mem_wd",  i, mem_wd,  vecs[i].e_wd);
            end
        end

        // Wrap: 3*DEPTH stores, mem_ready toggling, scoreboard on drain order.
        sent = 0; popped = 0; mcount = 0;
        for (int cyc = 0; cyc < 200 && popped < 3*DEPTH; cyc++) begin
            @(posedge clk); #1;
            drive(0, sent < 3*DEPTH, 32'h1000 + 32'(4*sent), 32'(100 + sent), 0, cyc[0]);
            @(negedge clk);
            check("wrap_stall",  cyc, 32'(stall),  32'(memwrite && mcount == DEPTH));
            check("wrap_mem_we", cyc, 32'(mem_we), 32'(mcount != 0));
            p_push = memwrite && mcount < DEPTH;
            p_pop  = mcount != 0 && mem_ready;
            if (p_pop) begin
                check("wrap_adr", popped, mem_adr, 32'h1000 + 32'(4*popped));
                check("wrap_wd",  popped, mem_wd,  32'(100 + popped));
            end
            sent   += int'(p_push);
            popped += int'(p_pop);
            mcount += int'(p_push) - int'(p_pop);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("wrap_all_drained", 0, 32'(popped), 32'(3*DEPTH));
        check("wrap_empty",       0, 32'(empty),  32'd1);

        // Reset with three stores pending discards them.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(0, 1, 32'h40 + 32'(4*i), 32'(i + 1), 0, 0);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("pre_rst_we", 0, 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("rst_empty",  0, 32'(empty),  32'd1);
        check("rst_mem_we", 0, 32'(mem_we), 32'd0);
        check("rst_adr",    0, mem_adr,     32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_write", i, 32'(mem_we), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
